// File: rtl/timer_pkg.sv
// Shared timer definitions: digit type, keypad limits and entry-FSM state codes.
// Used by time_entry and the downstream BCD down-counter blocks.
package timer_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t     KEY_MAX_DIGIT = 4'd9;
    localparam logic [2:0] MAX_DIGITS    = 3'd4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ENTRY = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    function automatic logic is_digit(input digit_t code);
        return code <= KEY_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Keypad conditioning: 2-flop synchronizer on strobe and code, then rising-edge detect.
// Only compiled in builds that define TIME_ENTRY_KEY_SYNC_EN.
`ifdef TIME_ENTRY_KEY_SYNC_EN
module key_sync
    import timer_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   key_valid_i,
    input  digit_t key_code_i,
    output logic   key_valid_o,
    output digit_t key_code_o
);

    logic   vld_meta_q, vld_sync_q, vld_prev_q;
    digit_t code_meta_q, code_sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_meta_q  <= 1'b0;
            vld_sync_q  <= 1'b0;
            vld_prev_q  <= 1'b0;
            code_meta_q <= '0;
            code_sync_q <= '0;
        end else begin
            vld_meta_q  <= key_valid_i;
            vld_sync_q  <= vld_meta_q;
            vld_prev_q  <= vld_sync_q;
            code_meta_q <= key_code_i;
            code_sync_q <= code_meta_q;
        end
    end

    // A held strobe yields a single accepted key.
    assign key_valid_o = vld_sync_q & ~vld_prev_q;
    assign key_code_o  = code_sync_q;

endmodule
`endif

// File: rtl/time_entry.sv
// Keypad MM:SS entry for the down-counters: shift-left digit buffer, one-cycle load pulse.
// Define TIME_ENTRY_KEY_SYNC_EN to synchronize and edge-detect the keypad inputs.
module time_entry
    import timer_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    input  logic         clear,
    input  logic         start,
    output logic         load,
    output logic [3:0]   min_tens,
    output logic [3:0]   min_units,
    output logic [3:0]   sec_tens,
    output logic [3:0]   sec_units,
    output logic [2:0]   digit_count,
    output logic         busy
);

    logic   kv;
    digit_t kc;

`ifdef TIME_ENTRY_KEY_SYNC_EN
    key_sync u_key_sync (
        .clk         (clk),
        .rst         (rst),
        .key_valid_i (key_valid),
        .key_code_i  (key_code),
        .key_valid_o (kv),
        .key_code_o  (kc)
    );
`else
    assign kv = key_valid;
    assign kc = key_code;
`endif

    logic [1:0]              state_q, state_d;
    logic [3:0][DIGIT_W-1:0] digits_q, digits_d;
    logic [2:0]              count_q, count_d;
    logic                    key_ok;

    assign key_ok = kv && is_digit(kc) && (count_q < MAX_DIGITS)
                    && (state_q == ST_IDLE || state_q == ST_ENTRY);

    // clear overrides everything; a digit and start in one ENTRY cycle both take effect.
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        count_d  = count_q;
        if (clear) begin
            state_d  = ST_IDLE;
            digits_d = '0;
            count_d  = '0;
        end else begin
            if (key_ok) begin
                digits_d = {digits_q[2:0], kc};
                count_d  = count_q + 3'd1;
                if (state_q == ST_IDLE) state_d = ST_ENTRY;
            end
            case (state_q)
                ST_ENTRY: if (start) state_d = ST_LOAD;
                ST_LOAD:  state_d = ST_HOLD;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            digits_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            count_q  <= count_d;
        end
    end

    // Decoded from state so an asynchronous reset truncates the pulse at once.
    assign load        = (state_q == ST_LOAD);
    assign busy        = (state_q == ST_ENTRY) || (state_q == ST_LOAD);
    assign min_tens    = digits_q[3];
    assign min_units   = digits_q[2];
    assign sec_tens    = digits_q[1];
    assign sec_units   = digits_q[0];
    assign digit_count = count_q;

endmodule

// File: doc/time_entry.md
TIME_ENTRY -- requirements
Module: time_entry

Interface
REQ-001 SHALL have no parameters; digit width fixed at 4 bits, buffer depth fixed at 4 digits (MM:SS).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 key_valid  input  1  keypad strobe; one accepted key per qualifying cycle.
REQ-005 key_code  input  4  key value; 0-9 are digits, 10-15 are ignored.
REQ-006 clear  input  1  discard entry, return to idle.
REQ-007 start  input  1  commit entered time to the downstream down-counters.
REQ-008 load  output  1  one-cycle pulse driving the counters' load inputs.
REQ-009 min_tens, min_units, sec_tens, sec_units  output  4 each  BCD digits driving the counters' in ports.
REQ-010 digit_count  output  3  digits held, 0-4.
REQ-011 busy  output  1  high in ENTRY and LOAD states.

Function
REQ-012 States SHALL be IDLE, ENTRY, LOAD and HOLD.
REQ-013 Digit entry SHALL shift left: an accepted digit d gives min_tens<=min_units, min_units<=sec_tens, sec_tens<=sec_units, sec_units<=d, and digit_count increments.
REQ-014 An accepted key SHALL appear on the digit outputs in the cycle after the qualifying key_valid cycle (1-cycle latency).
REQ-015 IDLE SHALL go to ENTRY on an accepted digit; ENTRY SHALL stay in ENTRY on further digits.
REQ-016 With digit_count==4, further digits SHALL be ignored; outputs and count are unchanged.
REQ-017 key_code 10-15 SHALL be ignored in every state.
REQ-018 start in ENTRY SHALL go to LOAD; LOAD SHALL assert load for exactly one cycle, then go to HOLD.
REQ-019 Digit outputs SHALL be stable during the LOAD cycle and throughout HOLD.
REQ-020 start in IDLE, LOAD or HOLD SHALL be ignored.
REQ-021 Keys in LOAD and HOLD SHALL be ignored.
REQ-022 clear in any state SHALL go to IDLE next cycle, zero all digits and digit_count, and deassert busy.
REQ-023 clear asserted together with start or key_valid SHALL take priority; no digit is shifted and no load pulse is issued.
REQ-024 start and an accepted key in the same ENTRY cycle SHALL shift the digit first, then go to LOAD; the loaded value includes that digit.
REQ-025 Seconds tens values 6-9 SHALL pass through unchanged; the seconds down-counter handles 60-99 entry.
REQ-026 No range checking or BCD arithmetic SHALL be performed beyond the digit filter.

Reset
REQ-027 rst low SHALL immediately force IDLE, all digits 0, digit_count 0, load 0 and busy 0, independent of clk.
REQ-028 rst asserted during LOAD SHALL truncate the load pulse; no pulse is issued after rst deasserts.
REQ-029 After rst deasserts, the first qualifying key SHALL be accepted normally.

Configuration
REQ-030 Macro TIME_ENTRY_KEY_SYNC_EN SHALL select key conditioning.
REQ-031 With TIME_ENTRY_KEY_SYNC_EN defined: key_valid and key_code SHALL pass through a 2-flop synchronizer, then a rising-edge detector; one key is accepted per key_valid rising edge; key-to-output latency is 3 cycles; a held key_valid gives one digit.
REQ-032 With TIME_ENTRY_KEY_SYNC_EN undefined: key_valid SHALL be used directly as a synchronous strobe; each high cycle is one key; latency per REQ-014.
REQ-033 The synchronizer flops SHALL reset to 0 on rst.

Structure
REQ-034 State encodings (IDLE, ENTRY, LOAD, HOLD), digit width, KEY_MAX_DIGIT=9 and MAX_DIGITS=4 SHALL live in shared package timer_pkg, used with the existing counter blocks.
REQ-035 Key synchronizer and edge detector SHALL be sub-module key_sync, instantiated only under TIME_ENTRY_KEY_SYNC_EN.

Verification
REQ-036 Keys 1,3,0 then start -> outputs 0,1,3,0; load high for exactly 1 cycle; HOLD; digit_count=3.
REQ-037 Keys 9,9,9,9,5 -> outputs 9,9,9,9; digit_count=4; the fifth key is ignored.
REQ-038 Keys 1,2 then key_code=12, then clear together with start -> no load pulse; all outputs 0; IDLE.
REQ-039 Key 7 with start in the same cycle -> sec_units=7; load pulses the following cycle.
REQ-040 rst low during the LOAD cycle -> load drops immediately; all outputs 0; no load pulse after release.
REQ-041 With TIME_ENTRY_KEY_SYNC_EN: key_valid high for 5 cycles with key_code=4 -> exactly one digit accepted, visible 3 cycles after the rising edge.
